// File: rtl/jk_excitation_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jk_excitation_driver_pkg
// Purpose  : Shared definitions for the JK excitation driver: FSM state
//            encoding and don't-care resolution policy constants.
// Contents : jk_state_e (2-bit state enum), DC_ZERO / DC_TOGGLE policies.
// Revision : 1.0 - initial release
// ============================================================================
package jk_excitation_driver_pkg;

  localparam int STATE_W = 2;

  // Don't-care resolution for the excitation table.
  //   DC_ZERO   : x -> 0, giving set/reset style drive (hold where possible)
  //   DC_TOGGLE : x -> 1, giving toggle style drive
  localparam int DC_ZERO   = 0;
  localparam int DC_TOGGLE = 1;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_WAIT  = 2'd2,
    S_CHECK = 2'd3
  } jk_state_e;

endpackage
`default_nettype wire

// File: rtl/jk_excitation_driver_excitation.sv
`default_nettype none
// ============================================================================
// Module   : jk_excitation
// Purpose  : Single-bit JK excitation table. Given the present flip-flop
//            output and the desired next state, produce the J/K inputs.
// Ports    : q      - present flip-flop output
//            target - desired next state
//            policy - don't-care resolution (0: x->0, 1: x->1)
//            j, k   - resolved excitation
// Revision : 1.0 - initial release
// ============================================================================
module jk_excitation (
  input  logic q,
  input  logic target,
  input  logic policy,
  output logic j,
  output logic k
);

  // When q = 0 only J matters (it must equal target); K is free.
  // When q = 1 only K matters (it must equal !target); J is free.
  // The free term takes the policy value.
  assign j = q ? policy  : target;
  assign k = q ? ~target : policy;

endmodule
`default_nettype wire

// File: rtl/jk_excitation_driver.sv
`default_nettype none
// ============================================================================
// Module   : jk_excitation_driver
// Purpose  : Drives a bank of JK flip-flops toward a requested target word.
//            A target is accepted over valid/ready, J/K excitation is derived
//            from the bank's present outputs, the bank is strobed once, and
//            after a settle period the bank feedback is compared to target.
// Ports    : clk, rst                 - clock, async active-high reset
//            in_valid/in_ready/in_target - target handshake
//            q_fb                     - Q outputs of the driven bank
//            j, k, jk_en              - bank excitation and clock enable
//            busy                     - transaction in progress
//            done, err, err_mask      - completion pulse and check result
// Revision : 1.0 - initial release
// ============================================================================
module jk_excitation_driver
  import jk_excitation_driver_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int DC_POLICY     = DC_ZERO
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             jk_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask
);

  localparam int   CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic POLICY = (DC_POLICY == DC_TOGGLE);

  jk_state_e        state;
  logic [CNT_W-1:0] settle_cnt;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] j_next;
  logic [WIDTH-1:0] k_next;
  logic [WIDTH-1:0] check_diff;

  // Excitation is computed from the live feedback and the incoming target so
  // that the registered J/K reflect q_fb as sampled on the accepting edge.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      jk_excitation u_exc (
        .q      (q_fb[i]),
        .target (in_target[i]),
        .policy (POLICY),
        .j      (j_next[i]),
        .k      (k_next[i])
      );
    end
  endgenerate

  assign check_diff = q_fb ^ target_q;

  // Ready must drop the instant reset is asserted, so it is not registered.
  assign in_ready = (state == S_IDLE) && !rst;
  assign busy     = !in_ready && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      target_q   <= '0;
      j          <= '0;
      k          <= '0;
      jk_en      <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_mask   <= '0;
    end else begin
      // done and err are single-cycle; err_mask is held until the next check.
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            target_q <= in_target;
            j        <= j_next;
            k        <= k_next;
            jk_en    <= 1'b1;
            state    <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          // The bank updates on this edge; return J/K to hold afterwards.
          jk_en      <= 1'b0;
          j          <= '0;
          k          <= '0;
          settle_cnt <= '0;
          state      <= (SETTLE_CYCLES == 0) ? S_CHECK : S_WAIT;
        end
        S_WAIT: begin
          if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            state <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        S_CHECK: begin
          err_mask <= check_diff;
          err      <= |check_diff;
          done     <= 1'b1;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
